// File: rtl/lbdr_pkg.sv
// Shared types and constants for the LBDR router: flit type codes, port order
// and the per-output allocator state.
package lbdr_pkg;

    localparam int NUM_PORTS = 5;

    typedef logic [2:0] flit_id_t;

    localparam flit_id_t HEADER  = 3'b001;
    localparam flit_id_t PAYLOAD = 3'b010;
    localparam flit_id_t TAIL    = 3'b100;

    typedef enum logic [2:0] {N = 3'd0, E = 3'd1, W = 3'd2, S = 3'd3, L = 3'd4} port_e;

    typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} alloc_state_e;

    function automatic logic [2:0] inc_mod5(input logic [2:0] p);
        return (p >= 3'd4) ? 3'd0 : p + 3'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter5.sv
// Five-way round-robin arbiter: first request found scanning upward from ptr,
// wrapping after port 4.
module rr_arbiter5
    import lbdr_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic [2:0]           ptr,
    output logic [NUM_PORTS-1:0] gnt,
    output logic [2:0]           idx,
    output logic                 any
);

    logic [2:0] cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = (ptr > 3'd4) ? 3'd0 : ptr;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (!any && req[cand]) begin
                any       = 1'b1;
                idx       = cand;
                gnt[cand] = 1'b1;
            end
            cand = inc_mod5(cand);
        end
    end

endmodule

// File: rtl/lbdr_switch_allocator.sv
// Per-output wormhole switch allocator: round-robin grant on HEADER, lock until
// TAIL, credit-based flow control toward the downstream buffers.
module lbdr_switch_allocator
    import lbdr_pkg::*;
#(
    parameter int CREDIT_DEPTH = 4,
    parameter int CW           = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [24:0] req,
    input  logic [14:0] flit_id,
    input  logic [4:0]  empty,
    input  logic [4:0]  credit_in,
    output logic [4:0]  read_en,
    output logic [14:0] xbar_sel,
    output logic [4:0]  valid_out
);

    localparam logic [CW-1:0] CRED_MAX = CW'(CREDIT_DEPTH);

    alloc_state_e         state_q  [NUM_PORTS];
    alloc_state_e         state_d  [NUM_PORTS];
    logic [2:0]           owner_q  [NUM_PORTS];
    logic [2:0]           owner_d  [NUM_PORTS];
    logic [2:0]           rr_q     [NUM_PORTS];
    logic [2:0]           rr_d     [NUM_PORTS];
    logic [CW-1:0]        credit_q [NUM_PORTS];
    logic [CW-1:0]        credit_d [NUM_PORTS];

    flit_id_t             fid      [NUM_PORTS];
    logic [NUM_PORTS-1:0] req_oh   [NUM_PORTS];
    logic [NUM_PORTS-1:0] elig     [NUM_PORTS];
    logic [NUM_PORTS-1:0] arb_gnt  [NUM_PORTS];
    logic [2:0]           arb_idx  [NUM_PORTS];
    logic [NUM_PORTS-1:0] arb_any;
    logic [NUM_PORTS-1:0] send;

    // A malformed multi-hot request row collapses to its lowest output.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            fid[i]    = flit_id[3*i +: 3];
            req_oh[i] = req[5*i +: 5] & (~req[5*i +: 5] + 5'd1);
        end
        for (int o = 0; o < NUM_PORTS; o++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                elig[o][i] = req_oh[i][o] & ~empty[i] & (fid[i] == HEADER);
            end
        end
    end

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
        rr_arbiter5 u_arb (
            .req (elig[o]),
            .ptr (rr_q[o]),
            .gnt (arb_gnt[o]),
            .idx (arb_idx[o]),
            .any (arb_any[o])
        );

        a_credit_sat: assert property (@(posedge clk) disable iff (rst)
            (credit_in[o] && !send[o]) |-> (credit_q[o] != CRED_MAX));
    end

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_in
        a_req_onehot: assert property (@(posedge clk) disable iff (rst)
            $onehot0(req[5*i +: 5]));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                state_q[o]  <= ST_IDLE;
                owner_q[o]  <= '0;
                rr_q[o]     <= '0;
                credit_q[o] <= CRED_MAX;
            end
        end else begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                state_q[o]  <= state_d[o];
                owner_q[o]  <= owner_d[o];
                rr_q[o]     <= rr_d[o];
                credit_q[o] <= credit_d[o];
            end
        end
    end

    // Next state: lock on grant, release the cycle after TAIL leaves.
    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            state_d[o] = state_q[o];
            owner_d[o] = owner_q[o];
            rr_d[o]    = rr_q[o];
            if (state_q[o] == ST_IDLE) begin
                send[o] = arb_any[o] && (credit_q[o] != '0);
                if (send[o]) begin
                    state_d[o] = ST_BUSY;
                    owner_d[o] = arb_idx[o];
                end
            end else begin
                send[o] = !empty[owner_q[o]] && (credit_q[o] != '0);
                if (send[o] && fid[owner_q[o]] == TAIL) begin
                    state_d[o] = ST_IDLE;
                    rr_d[o]    = inc_mod5(owner_q[o]);
                end
            end
            case ({send[o], credit_in[o]})
                2'b10:   credit_d[o] = credit_q[o] - CW'(1);
                2'b01:   credit_d[o] = (credit_q[o] == CRED_MAX) ? credit_q[o] : credit_q[o] + CW'(1);
                default: credit_d[o] = credit_q[o];
            endcase
        end
    end

    always_comb begin
        read_en   = '0;
        valid_out = '0;
        xbar_sel  = '0;
        if (!rst) begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                valid_out[o] = send[o];
                if (state_q[o] == ST_BUSY) begin
                    xbar_sel[3*o +: 3] = owner_q[o];
                    if (send[o]) read_en = read_en | (NUM_PORTS'(1) << owner_q[o]);
                end else if (send[o]) begin
                    xbar_sel[3*o +: 3] = arb_idx[o];
                    read_en            = read_en | arb_gnt[o];
                end
            end
        end
    end

endmodule

// File: tb/tb_lbdr_switch_allocator.sv
// Directed bench for lbdr_switch_allocator: single packet, contention, credit
// starvation, owner gaps, parallel outputs and mid-packet reset.
module tb_lbdr_switch_allocator;
    import lbdr_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [24:0] req;
    logic [14:0] flit_id;
    logic [4:0]  empty;
    logic [4:0]  credit_in;
    logic [4:0]  read_en;
    logic [14:0] xbar_sel;
    logic [4:0]  valid_out;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    lbdr_switch_allocator #(.CREDIT_DEPTH(4), .CW(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .flit_id   (flit_id),
        .empty     (empty),
        .credit_in (credit_in),
        .read_en   (read_en),
        .xbar_sel  (xbar_sel),
        .valid_out (valid_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_out(input string tag, input logic [4:0] re, input logic [4:0] vo,
                           input logic [14:0] xs);
        chk({tag, ".read_en"},   32'(read_en),   32'(re));
        chk({tag, ".valid_out"}, 32'(valid_out), 32'(vo));
        chk({tag, ".xbar_sel"},  32'(xbar_sel),  32'(xs));
    endtask

    task automatic clr();
        req = '0; flit_id = '0; empty = '1; credit_in = '0;
    endtask

    task automatic put(input int i, input int o, input flit_id_t f);
        req[5*i +: 5]     = 5'(1 << o);
        flit_id[3*i +: 3] = f;
        empty[i]          = 1'b0;
    endtask

    task automatic drop(input int i);
        req[5*i +: 5]     = '0;
        flit_id[3*i +: 3] = '0;
        empty[i]          = 1'b1;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        clr(); rst = 1'b1; step(); rst = 1'b0;
    endtask

    initial begin
        // Reset: outputs gated even with a live request, credits at depth
        clr(); rst = 1'b1; put(2, 1, HEADER); #2;
        chk_out("rst_hold", 5'b00000, 5'b00000, 15'h0000);
        chk("rst_credit", 32'(dut.credit_q[1]), 4);
        step(); rst = 1'b0; clr();

        // Single packet W -> E
        put(2, 1, HEADER); #2;  chk_out("s1_hdr",  5'b00100, 5'b00010, 15'h0010);
        step(); put(2, 1, PAYLOAD); #2; chk_out("s1_pay",  5'b00100, 5'b00010, 15'h0010);
        step(); put(2, 1, TAIL);    #2; chk_out("s1_tail", 5'b00100, 5'b00010, 15'h0010);
        step(); drop(2); #2;    chk_out("s1_idle", 5'b00000, 5'b00000, 15'h0000);
        chk("s1_rr", 32'(dut.rr_q[1]), 3);
        chk("s1_state", 32'(dut.state_q[1]), 0);
        chk("s1_credit", 32'(dut.credit_q[1]), 1);
        do_reset();

        // Contention N and S -> L, same-cycle send+credit keeps the count
        put(0, 4, HEADER); put(3, 4, HEADER); #2;
        chk_out("s2_n_hdr", 5'b00001, 5'b10000, 15'h0000);
        step(); put(0, 4, PAYLOAD); credit_in[4] = 1'b1; #2;
        chk_out("s2_n_pay", 5'b00001, 5'b10000, 15'h0000);
        step(); put(0, 4, TAIL); #2;
        chk_out("s2_n_tail", 5'b00001, 5'b10000, 15'h0000);
        step(); drop(0); #2;
        chk_out("s2_s_hdr", 5'b01000, 5'b10000, 15'h3000);
        step(); put(3, 4, TAIL); #2;
        chk_out("s2_s_tail", 5'b01000, 5'b10000, 15'h3000);
        step(); drop(3); credit_in = '0; #2;
        chk_out("s2_idle", 5'b00000, 5'b00000, 15'h0000);
        chk("s2_rr", 32'(dut.rr_q[4]), 4);
        chk("s2_credit", 32'(dut.credit_q[4]), 3);
        do_reset();

        // Credit starvation: 6-flit packet L -> S
        put(4, 3, HEADER); #2; chk_out("s3_f0", 5'b10000, 5'b01000, 15'h0800);
        for (int k = 1; k < 4; k++) begin
            step(); put(4, 3, PAYLOAD); #2;
            chk_out($sformatf("s3_f%0d", k), 5'b10000, 5'b01000, 15'h0800);
        end
        step(); #2; chk_out("s3_stall", 5'b00000, 5'b00000, 15'h0800);
        credit_in[3] = 1'b1;
        step(); credit_in[3] = 1'b0; #2; chk_out("s3_one", 5'b10000, 5'b01000, 15'h0800);
        step(); #2; chk_out("s3_stall2", 5'b00000, 5'b00000, 15'h0800);
        credit_in[3] = 1'b1;
        step(); put(4, 3, TAIL); #2; chk_out("s3_tail", 5'b10000, 5'b01000, 15'h0800);
        step(); credit_in = '0; drop(4); #2;
        chk_out("s3_idle", 5'b00000, 5'b00000, 15'h0000);
        chk("s3_credit", 32'(dut.credit_q[3]), 1);
        do_reset();

        // Owner empty mid-packet E -> W while N waits with a HEADER
        put(1, 2, HEADER); #2; chk_out("s4_hdr", 5'b00010, 5'b00100, 15'h0040);
        step(); empty[1] = 1'b1; put(0, 2, HEADER); #2;
        chk_out("s4_gap0", 5'b00000, 5'b00000, 15'h0040);
        for (int k = 1; k < 3; k++) begin
            step(); #2; chk_out($sformatf("s4_gap%0d", k), 5'b00000, 5'b00000, 15'h0040);
        end
        step(); put(1, 2, PAYLOAD); #2; chk_out("s4_resume", 5'b00010, 5'b00100, 15'h0040);
        step(); put(1, 2, TAIL);    #2; chk_out("s4_tail",   5'b00010, 5'b00100, 15'h0040);
        step(); drop(1); #2;        chk_out("s4_next",   5'b00001, 5'b00100, 15'h0000);
        do_reset();

        // Parallel N->S, E->W, L->N
        put(0, 3, HEADER); put(1, 2, HEADER); put(4, 0, HEADER); #2;
        chk_out("s5_hdr", 5'b10011, 5'b01101, 15'h0044);
        step(); put(0, 3, TAIL); put(1, 2, TAIL); put(4, 0, TAIL); #2;
        chk_out("s5_tail", 5'b10011, 5'b01101, 15'h0044);
        step(); clr(); #2; chk_out("s5_idle", 5'b00000, 5'b00000, 15'h0000);
        do_reset();

        // Async reset mid-packet S -> E
        put(3, 1, HEADER); #2; chk_out("s6_hdr", 5'b01000, 5'b00010, 15'h0018);
        step(); put(3, 1, PAYLOAD);
        step(); #2; chk_out("s6_pay", 5'b01000, 5'b00010, 15'h0018);
        chk("s6_credit_pre", 32'(dut.credit_q[1]), 2);
        rst = 1'b1; #1;
        chk_out("s6_rst", 5'b00000, 5'b00000, 15'h0000);
        chk("s6_state", 32'(dut.state_q[1]), 0);
        chk("s6_credit", 32'(dut.credit_q[1]), 4);
        #2; rst = 1'b0;
        step(); #2; chk_out("s6_drop", 5'b00000, 5'b00000, 15'h0000);
        step(); put(3, 1, HEADER); #2; chk_out("s6_new", 5'b01000, 5'b00010, 15'h0018);
        step(); clr();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
